// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: shared types for the diaosi memory responder.
//   arb_state_t : arbiter FSM states.
//   grant_t     : which cache owns the in-flight RAM access.
//   WORD_W      : width of addresses and data words.
//   dcache_req  : a dcache access is pending when either enable is high.
package diaosi_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I_DIAOSI = 1'b0,
        GNT_D_DIAOSI = 1'b1
    } grant_t;

    function automatic logic dcache_req(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/diaosi_mem_responder_if.sv
// diaosi_mem_responder_if: bundle of the icache, dcache and RAM signals seen
// by the memory responder.
//   slave  : responder view (cache requests and RAM results in, waits/loads and
//            RAM commands out).
//   master : environment view (caches plus RAM model).
interface diaosi_mem_responder_if;
    import diaosi_types_pkg::*;

    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/diaosi_arb_fair_cnt.sv
// diaosi_arb_fair_cnt: saturating count of consecutive dcache grants made
// while the icache is waiting.
//   CLK, RST : clock, asynchronous active-high reset.
//   dgrant   : a dcache grant is being made this cycle.
//   ipend    : icache request is pending this cycle.
//   igrant   : an icache grant is being made this cycle.
//   at_max   : the count has reached STARVE_MAX, so the icache must win next.
module diaosi_arb_fair_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic dgrant,
    input  logic ipend,
    input  logic igrant,
    output logic at_max
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: any grant that is not starving a pending icache clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (igrant || (dgrant && !ipend)) begin
            cnt_d = CNT_ZERO;
        end else if (dgrant && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/diaosi_mem_responder.sv
// diaosi_mem_responder: serves icache and dcache word accesses over a single
// RAM port, one access at a time. The dcache wins ties unless the icache has
// been passed over STARVE_MAX times in a row.
//   CLK, RST : clock, asynchronous active-high reset.
//   bus      : slave view of the cache/RAM signal bundle. All outputs on it
//              (waits, loads, RAM command) come straight from flops.
module diaosi_mem_responder
    import diaosi_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    diaosi_mem_responder_if.slave bus
);

    arb_state_t        state_q, state_d;
    grant_t            gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic [WORD_W-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0] ram_store_q, ram_store_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;
    logic              iwait_q, iwait_d;
    logic              dwait_q, dwait_d;

    logic dreq_s;
    logic dgrant_s;
    logic igrant_s;
    logic at_max_s;

    diaosi_arb_fair_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fair_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .dgrant (dgrant_s),
        .ipend  (bus.iREN),
        .igrant (igrant_s),
        .at_max (at_max_s)
    );

    // Arbitration, RAM command and completion handling.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
        iload_d     = iload_q;
        dload_d     = dload_q;
        iwait_d     = 1'b1;
        dwait_d     = 1'b1;
        dgrant_s    = 1'b0;
        igrant_s    = 1'b0;
        dreq_s      = dcache_req(bus.dREN, bus.dWEN);

        case (state_q)
            ARB_IDLE: begin
                // dWEN dominates dREN, so a double request becomes a write.
                if (dreq_s && !(bus.iREN && at_max_s)) begin
                    dgrant_s    = 1'b1;
                    state_d     = ARB_DBUSY;
                    gnt_d       = GNT_D_DIAOSI;
                    wr_d        = bus.dWEN;
                    ram_ren_d   = !bus.dWEN;
                    ram_wen_d   = bus.dWEN;
                    ram_addr_d  = bus.daddr;
                    ram_store_d = bus.dstore;
                end else if (bus.iREN) begin
                    igrant_s    = 1'b1;
                    state_d     = ARB_IBUSY;
                    gnt_d       = GNT_I_DIAOSI;
                    wr_d        = 1'b0;
                    ram_ren_d   = 1'b1;
                    ram_wen_d   = 1'b0;
                    ram_addr_d  = bus.iaddr;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_IBUSY, ARB_DBUSY: begin
                if (bus.ramready) begin
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    state_d   = ARB_DONE;
                    if (gnt_q == GNT_I_DIAOSI) begin
                        iload_d = bus.ramload;
                        iwait_d = 1'b0;
                    end else begin
                        if (!wr_q) begin
                            dload_d = bus.ramload;
                        end else begin
                            dload_d = dload_q;
                        end
                        dwait_d = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_I_DIAOSI;
            wr_q        <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= {WORD_W{1'b0}};
            ram_store_q <= {WORD_W{1'b0}};
            iload_q     <= {WORD_W{1'b0}};
            dload_q     <= {WORD_W{1'b0}};
            iwait_q     <= 1'b1;
            dwait_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
            iload_q     <= iload_d;
            dload_q     <= dload_d;
            iwait_q     <= iwait_d;
            dwait_q     <= dwait_d;
        end
    end

    assign bus.iwait    = iwait_q;
    assign bus.iload    = iload_q;
    assign bus.dwait    = dwait_q;
    assign bus.dload    = dload_q;
    assign bus.ramREN   = ram_ren_q;
    assign bus.ramWEN   = ram_wen_q;
    assign bus.ramaddr  = ram_addr_q;
    assign bus.ramstore = ram_store_q;

endmodule

// File: tb/tb_diaosi_mem_responder.sv
// tb_diaosi_mem_responder: directed vector table, hand-written corner cases
// (starvation bound, reset mid-access) and a randomized run against a
// transaction-level model of the responder with its own RAM contents.
module tb_diaosi_mem_responder;

    localparam int STARVE_MAX = 4;
    localparam int NV = 20;
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    diaosi_mem_responder_if bus ();

    diaosi_mem_responder #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic        rdy;
        logic [31:0] rload;
        logic        e_iw;
        logic        e_dw;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_ra;
        logic [31:0] e_rs;
        logic [31:0] e_il;
        logic [31:0] e_dl;
    } vec_t;

    vec_t tv [NV];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic clr_inputs();
        bus.iREN = 1'b0; bus.iaddr = 32'h0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = 32'h0; bus.dstore = 32'h0; bus.ramready = 1'b0; bus.ramload = 32'h0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Random-run model state.
    logic [31:0] mem [16];
    int          ph;
    int          m_lat;
    int          m_starve;
    logic        m_gd;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] exp_il;
    logic [31:0] exp_dl;
    logic        i_pend;
    logic        d_pend;
    logic        take_d;
    int          kind;
    int          g;

    initial begin
        // iren iaddr dren dwen daddr dstore rdy rload | iw dw ren wen ra rs il dl
        tv[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0};
        tv[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0};
        tv[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 32'h0};
        tv[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 32'h0};
        tv[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 32'h0};
        tv[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tv[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tv[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tv[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h100, 32'h12345678, 1'b1, 32'hAAAA5555, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tv[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tv[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
        tv[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
        tv[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
        tv[13] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
        tv[14] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0,      32'hDEADBEEF, 32'h0};
        tv[15] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0,        32'hDEADBEEF, 32'h22222222};
        tv[16] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0,        32'hDEADBEEF, 32'h22222222};
        tv[17] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44,  32'h0,        32'hDEADBEEF, 32'h22222222};
        tv[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        32'h33333333, 32'h22222222};
        tv[19] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        32'h33333333, 32'h22222222};

        // ---------------- directed vector table ----------------
        do_reset();
        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            chk($sformatf("vec%0d", k),
                {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iload, bus.dload},
                {tv[k].e_iw, tv[k].e_dw, tv[k].e_ren, tv[k].e_wen, tv[k].e_ra, tv[k].e_rs, tv[k].e_il, tv[k].e_dl});
            bus.iREN = tv[k].iren; bus.iaddr = tv[k].iaddr; bus.dREN = tv[k].dren; bus.dWEN = tv[k].dwen;
            bus.daddr = tv[k].daddr; bus.dstore = tv[k].dstore; bus.ramready = tv[k].rdy; bus.ramload = tv[k].rload;
        end

        // ---------------- starvation bound ----------------
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h500;
        g = 0;
        for (int c = 0; c < 100 && g < 10; c++) begin
            @(posedge clk); #1;
            bus.ramready = 1'b0;
            if (bus.ramREN) begin
                chk($sformatf("starve_grant%0d", g), bus.ramaddr, (g % 5 == 4) ? 32'h80 : 32'h500);
                g++;
                bus.ramready = 1'b1;
                bus.ramload  = 32'(g);
            end
        end
        chk("starve_grant_count", g, 10);

        // ---------------- reset mid-access ----------------
        do_reset();
        bus.dWEN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_wen", {bus.ramWEN, bus.ramaddr}, {1'b1, 32'h600});
        #2; rst = 1'b1; #1;
        chk("rst_mid_outputs", {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait, bus.ramaddr, bus.ramstore},
            {1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0});
        clr_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.iREN = 1'b1; bus.iaddr = 32'h700;
        @(posedge clk); #1;
        chk("rst_after_req", {bus.ramREN, bus.ramWEN, bus.ramaddr}, {1'b1, 1'b0, 32'h700});
        bus.ramready = 1'b1; bus.ramload = 32'h77;
        @(posedge clk); #1;
        chk("rst_after_done", {bus.iwait, bus.dwait, bus.iload}, {1'b0, 1'b1, 32'h77});
        clr_inputs();

        // ---------------- randomized run against model ----------------
        do_reset();
        for (int a = 0; a < 16; a++) mem[a] = $urandom;
        ph = PH_IDLE; m_lat = 0; m_starve = 0; m_gd = 1'b0; m_wr = 1'b0;
        m_addr = 32'h0; m_data = 32'h0; exp_il = 32'h0; exp_dl = 32'h0;
        i_pend = 1'b0; d_pend = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            chk("rnd_iwait", bus.iwait, !(ph == PH_DONE && !m_gd));
            chk("rnd_dwait", bus.dwait, !(ph == PH_DONE && m_gd));
            chk("rnd_iload", bus.iload, exp_il);
            chk("rnd_dload", bus.dload, exp_dl);
            chk("rnd_ramren", bus.ramREN, (ph == PH_BUSY) && !m_wr);
            chk("rnd_ramwen", bus.ramWEN, (ph == PH_BUSY) && m_wr);
            if (ph == PH_BUSY) chk("rnd_ramaddr", bus.ramaddr, m_addr);
            if (ph == PH_BUSY && m_wr) chk("rnd_ramstore", bus.ramstore, m_data);

            // cache agents: a request stays up until its wait pulse is seen
            if (ph == PH_DONE && !m_gd) i_pend = 1'b0;
            if (ph == PH_DONE && m_gd)  d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 3) == 0) i_pend = 1'b1;
            if (!d_pend && $urandom_range(0, 2) == 0) d_pend = 1'b1;
            kind = $urandom_range(0, 2);
            bus.iREN   = i_pend;
            bus.iaddr  = 32'($urandom_range(0, 15));
            bus.dREN   = d_pend && (kind != 1);
            bus.dWEN   = d_pend && (kind != 0);
            bus.daddr  = 32'($urandom_range(0, 15));
            bus.dstore = $urandom;

            // RAM side: answer after the chosen latency, noise otherwise
            if (ph == PH_BUSY && m_lat == 0) begin
                bus.ramready = 1'b1;
                bus.ramload  = m_wr ? $urandom : mem[m_addr[3:0]];
            end else if (ph == PH_BUSY) begin
                bus.ramready = 1'b0;
                bus.ramload  = $urandom;
            end else begin
                bus.ramready = 1'($urandom_range(0, 1));
                bus.ramload  = $urandom;
            end

            // advance the transaction-level model by one cycle
            if (ph == PH_IDLE) begin
                if (bus.dREN || bus.dWEN || bus.iREN) begin
                    take_d = (bus.dREN || bus.dWEN) && !(bus.iREN && m_starve == STARVE_MAX);
                    if (take_d) m_starve = bus.iREN ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                    else m_starve = 0;
                    m_gd   = take_d;
                    m_wr   = take_d && bus.dWEN;
                    m_addr = take_d ? bus.daddr : bus.iaddr;
                    m_data = bus.dstore;
                    m_lat  = $urandom_range(0, 3);
                    ph     = PH_BUSY;
                end
            end else if (ph == PH_BUSY) begin
                if (m_lat == 0) begin
                    if (m_wr) mem[m_addr[3:0]] = m_data;
                    else if (m_gd) exp_dl = bus.ramload;
                    else exp_il = bus.ramload;
                    ph = PH_DONE;
                end else begin
                    m_lat = m_lat - 1;
                end
            end else begin
                ph = PH_IDLE;
            end
        end
        clr_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
